// File: rtl/biquad_mac_scheduler_pkg.sv
// Coefficient tables, FSM state type and saturation limits shared by the biquad scheduler.
// Coefficients are stored in Q(64-Q_SHIFT).Q_SHIFT and rounded toward zero.
package lp_coeff_pkg;

   localparam int unsigned CW      = 64;
   localparam int unsigned Q_SHIFT = 30;
   localparam int unsigned TAPS    = 5;
   localparam int          SAT_MAX = 32767;
   localparam int          SAT_MIN = -32768;

   typedef logic signed [CW-1:0] coeff_t;

   typedef enum logic [1:0] {
      IDLE,
      MAC,
      WB,
      DONE
   } state_e;

   // num / 2^k scaled by 2^Q_SHIFT; SV integer division truncates toward zero.
   function automatic coeff_t coeff_q(input longint num, input int unsigned k);
      return coeff_t'((num * (longint'(1) <<< Q_SHIFT)) / (longint'(1) <<< k));
   endfunction

   localparam coeff_t ONE = coeff_t'(longint'(1) <<< Q_SHIFT);

   localparam coeff_t B0 [8] = '{ONE, coeff_q(1, 8), coeff_q(89, 12), coeff_q(37, 9),
                                 coeff_q(113, 9), ONE, ONE, ONE};
   localparam coeff_t B1 [8] = '{'0, coeff_q(2, 8), coeff_q(178, 12), coeff_q(74, 9),
                                 coeff_q(226, 9), '0, '0, '0};
   localparam coeff_t B2 [8] = '{'0, coeff_q(1, 8), coeff_q(89, 12), coeff_q(37, 9),
                                 coeff_q(113, 9), '0, '0, '0};
   localparam coeff_t A1 [8] = '{'0, coeff_q(29, 4), coeff_q(99, 6), coeff_q(71, 6),
                                 coeff_q(5, 4), '0, '0, '0};
   localparam coeff_t A2 [8] = '{'0, coeff_q(-53, 6), coeff_q(-5, 3), coeff_q(-25, 6),
                                 coeff_q(-3, 4), '0, '0, '0};

endpackage

// File: rtl/biquad_mac_scheduler_if.sv
// Sample-side and result-side signals of the biquad scheduler.
interface biquad_mac_scheduler_if #(
   parameter int unsigned NCH = 2
);

   logic [2:0]       filter;
   logic             sample_valid;
   logic [16*NCH-1:0] in_data;
   logic [16*NCH-1:0] out_data;
   logic             out_valid;
   logic             busy;
   logic             overrun;

   modport master (
      output filter, sample_valid, in_data,
      input  out_data, out_valid, busy, overrun
   );

   modport slave (
      input  filter, sample_valid, in_data,
      output out_data, out_valid, busy, overrun
   );

endinterface

// File: rtl/biquad_mac_scheduler_mac_unit.sv
// Shared multiply-shift-accumulate: acc += (op_a * op_b) >>> SHIFT on each enabled cycle.
module mac_unit #(
   parameter int unsigned W     = 64,
   parameter int unsigned SHIFT = 30
) (
   input  logic                clk_144,
   input  logic                reset_n,
   input  logic                clr,
   input  logic                en,
   input  logic signed [W-1:0] op_a,
   input  logic signed [W-1:0] op_b,
   output logic signed [W-1:0] acc
);

   logic signed [W-1:0] prod;

   always_comb begin
      prod = op_a * op_b;
      prod = prod >>> SHIFT;
   end

   always_ff @(posedge clk_144 or negedge reset_n) begin
      if (!reset_n) begin
         acc <= '0;
      end else if (clr) begin
         acc <= '0;
      end else if (en) begin
         acc <= acc + prod;
      end
   end

endmodule

// File: rtl/biquad_mac_scheduler.sv
// Time-multiplexed biquad lowpass: one MAC sequenced over five taps and NCH channels per sample.
module biquad_mac_scheduler
   import lp_coeff_pkg::*;
#(
   parameter int unsigned NCH   = 2,
   parameter int unsigned W     = 64,
   parameter int unsigned SHIFT = 30
) (
   input logic                    clk_144,
   input logic                    reset_n,
   biquad_mac_scheduler_if.slave  bus
);

   localparam int DS = int'(Q_SHIFT) - int'(SHIFT);
   localparam logic signed [W-1:0] SAT_HI = W'(SAT_MAX);
   localparam logic signed [W-1:0] SAT_LO = W'(SAT_MIN);

   state_e state_q, state_d;
   logic [2:0] tap_q, ch_q, filt_q;
   logic busy_q, overrun_q, out_valid_q;
   logic accept, mac_clr, mac_en, wb, commit;
   logic [16*NCH-1:0] x0_q, stage_q, out_q;
   logic signed [W-1:0] x1 [NCH];
   logic signed [W-1:0] x2 [NCH];
   logic signed [W-1:0] y1 [NCH];
   logic signed [W-1:0] y2 [NCH];
   logic signed [W-1:0] x0_cur, x1_cur, x2_cur, y1_cur, y2_cur;
   logic signed [W-1:0] op_a, op_b, acc;

   function automatic logic signed [W-1:0] scale(input coeff_t c);
      if (DS >= 0) return W'(c >>> DS);
      else return W'(c <<< (-DS));
   endfunction

   function automatic logic [15:0] sat16(input logic signed [W-1:0] v);
      if (v > SAT_HI) return 16'h7fff;
      else if (v < SAT_LO) return 16'h8000;
      else return v[15:0];
   endfunction

   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      mac_clr = 1'b0;
      mac_en  = 1'b0;
      wb      = 1'b0;
      commit  = 1'b0;
      unique case (state_q)
         IDLE: begin
            // busy_q is still high in the out_valid cycle, so that strobe is dropped
            if (bus.sample_valid && !busy_q) begin
               accept  = 1'b1;
               mac_clr = 1'b1;
               state_d = MAC;
            end
         end
         MAC: begin
            mac_en = 1'b1;
            if (tap_q == 3'(TAPS - 1)) state_d = WB;
         end
         WB: begin
            wb      = 1'b1;
            mac_clr = 1'b1;
            state_d = (ch_q == 3'(NCH - 1)) ? DONE : MAC;
         end
         DONE: begin
            commit  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_144 or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         tap_q       <= '0;
         ch_q        <= '0;
         busy_q      <= 1'b0;
         overrun_q   <= 1'b0;
         out_valid_q <= 1'b0;
         out_q       <= '0;
      end else begin
         state_q     <= state_d;
         out_valid_q <= commit;
         if (accept) begin
            tap_q <= '0;
            ch_q  <= '0;
         end else begin
            if (mac_en) tap_q <= (tap_q == 3'(TAPS - 1)) ? '0 : tap_q + 3'd1;
            if (wb) ch_q <= ch_q + 3'd1;
         end
         if (accept) busy_q <= 1'b1;
         else if (state_q == IDLE) busy_q <= 1'b0;
         if (bus.sample_valid && busy_q) overrun_q <= 1'b1;
         if (commit) out_q <= stage_q;
      end
   end

   always_ff @(posedge clk_144 or negedge reset_n) begin
      if (!reset_n) begin
         filt_q  <= '0;
         x0_q    <= '0;
         stage_q <= '0;
         for (int unsigned c = 0; c < NCH; c++) begin
            x1[c] <= '0;
            x2[c] <= '0;
            y1[c] <= '0;
            y2[c] <= '0;
         end
      end else if (accept) begin
         filt_q <= bus.filter;
         x0_q   <= bus.in_data;
         if (bus.filter != filt_q) begin
            for (int unsigned c = 0; c < NCH; c++) begin
               x1[c] <= '0;
               x2[c] <= '0;
               y1[c] <= '0;
               y2[c] <= '0;
            end
         end
      end else if (wb) begin
         for (int unsigned c = 0; c < NCH; c++) begin
            if (3'(c) == ch_q) begin
               x2[c] <= x1[c];
               x1[c] <= x0_cur;
               y2[c] <= y1[c];
               y1[c] <= acc;
               stage_q[16*c +: 16] <= sat16(acc);
            end
         end
      end
   end

   always_comb begin
      x0_cur = '0;
      x1_cur = '0;
      x2_cur = '0;
      y1_cur = '0;
      y2_cur = '0;
      for (int unsigned c = 0; c < NCH; c++) begin
         if (3'(c) == ch_q) begin
            x0_cur = W'($signed(x0_q[16*c +: 16]));
            x1_cur = x1[c];
            x2_cur = x2[c];
            y1_cur = y1[c];
            y2_cur = y2[c];
         end
      end
   end

   always_comb begin
      op_a = '0;
      op_b = '0;
      case (tap_q)
         3'd0: begin op_a = x0_cur; op_b = scale(B0[filt_q]); end
         3'd1: begin op_a = x1_cur; op_b = scale(B1[filt_q]); end
         3'd2: begin op_a = x2_cur; op_b = scale(B2[filt_q]); end
         3'd3: begin op_a = y1_cur; op_b = scale(A1[filt_q]); end
         3'd4: begin op_a = y2_cur; op_b = scale(A2[filt_q]); end
         default: begin op_a = '0; op_b = '0; end
      endcase
   end

   mac_unit #(
      .W     (W),
      .SHIFT (SHIFT)
   ) u_mac (
      .clk_144 (clk_144),
      .reset_n (reset_n),
      .clr     (mac_clr),
      .en      (mac_en),
      .op_a    (op_a),
      .op_b    (op_b),
      .acc     (acc)
   );

   assign bus.out_data  = out_q;
   assign bus.out_valid = out_valid_q;
   assign bus.busy      = busy_q;
   assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_biquad_mac_scheduler.sv
// Scoreboard bench: driver pushes model results per accepted strobe, monitor checks on out_valid.
`timescale 1ns/1ps
module tb_biquad_mac_scheduler;

   localparam int NCH = 2;
   localparam int LAT = 6*NCH + 1;

   typedef struct {
      logic [16*NCH-1:0] data;
      int                cyc;
   } exp_t;

   logic clk_144 = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk_144 = ~clk_144;

   biquad_mac_scheduler_if #(.NCH(NCH)) bus();

   biquad_mac_scheduler #(.NCH(NCH), .W(64), .SHIFT(30)) dut (
      .clk_144 (clk_144),
      .reset_n (reset_n),
      .bus     (bus)
   );

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   bit running = 1'b0;
   exp_t sb[$];
   int busy_from = -100;
   int busy_to   = -100;
   int ovr_at    = -1;
   logic [16*NCH-1:0] last_out = '0;

   // behavioural filter: coefficient values as rationals, histories per channel
   longint mx1[NCH], mx2[NCH], my1[NCH], my2[NCH];
   int m_filt = 0;
   longint bn [5] = '{0, 1, 89, 37, 113};
   longint bd [5] = '{1, 256, 4096, 512, 512};
   longint a1n[5] = '{0, 29, 99, 71, 5};
   longint a1d[5] = '{1, 16, 64, 64, 16};
   longint a2n[5] = '{0, -53, -5, -25, -3};
   longint a2d[5] = '{1, 64, 8, 64, 16};

   always @(posedge clk_144) cyc <= cyc + 1;

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic model_clear();
      for (int c = 0; c < NCH; c++) begin
         mx1[c] = 0; mx2[c] = 0; my1[c] = 0; my2[c] = 0;
      end
   endtask

   task automatic model_sample(input int f, input logic [16*NCH-1:0] din,
                               output logic [16*NCH-1:0] dout);
      longint one, b0, b1, b2, a1, a2, x0, y;
      int k;
      one = longint'(1) <<< 30;
      if (f != m_filt) model_clear();
      m_filt = f;
      k = (f >= 1 && f <= 4) ? f : 0;
      if (k == 0) begin
         b0 = one; b1 = 0; b2 = 0; a1 = 0; a2 = 0;
      end else begin
         b0 = bn[k] * one / bd[k];
         b1 = 2 * bn[k] * one / bd[k];
         b2 = b0;
         a1 = a1n[k] * one / a1d[k];
         a2 = a2n[k] * one / a2d[k];
      end
      dout = '0;
      for (int c = 0; c < NCH; c++) begin
         x0 = longint'($signed(din[16*c +: 16]));
         y = ((x0 * b0) >>> 30) + ((mx1[c] * b1) >>> 30) + ((mx2[c] * b2) >>> 30)
           + ((my1[c] * a1) >>> 30) + ((my2[c] * a2) >>> 30);
         if (y > 32767) dout[16*c +: 16] = 16'h7fff;
         else if (y < -32768) dout[16*c +: 16] = 16'h8000;
         else dout[16*c +: 16] = 16'(y);
         mx2[c] = mx1[c]; mx1[c] = x0;
         my2[c] = my1[c]; my1[c] = y;
      end
   endtask

   // monitor
   always @(negedge clk_144) begin
      exp_t e;
      if (reset_n && running) begin
         chk("busy", longint'(bus.busy), longint'(cyc >= busy_from && cyc <= busy_to));
         chk("overrun", longint'(bus.overrun), longint'(ovr_at >= 0 && cyc >= ovr_at));
         if (bus.out_valid) begin
            if (sb.size() == 0) begin
               chk("unexpected_out_valid", 1, 0);
            end else begin
               e = sb.pop_front();
               chk("latency_cycle", cyc, e.cyc);
               for (int c = 0; c < NCH; c++)
                  chk($sformatf("out_ch%0d", c), longint'($signed(bus.out_data[16*c +: 16])),
                      longint'($signed(e.data[16*c +: 16])));
               last_out = e.data;
            end
         end else begin
            chk("out_hold", longint'(bus.out_data), longint'(last_out));
         end
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(negedge clk_144);
         bus.sample_valid = 1'b0;
         bus.filter  = 3'($urandom_range(0, 7));
         bus.in_data = (16*NCH)'($urandom);
      end
   endtask

   task automatic strobe(input int f, input logic [16*NCH-1:0] d, input bit accepted);
      logic [16*NCH-1:0] o;
      bus.filter = 3'(f);
      bus.in_data = d;
      bus.sample_valid = 1'b1;
      if (accepted) begin
         model_sample(f, d, o);
         sb.push_back('{data: o, cyc: cyc + 1 + LAT});
         busy_from = cyc + 1;
         busy_to   = cyc + 1 + LAT;
      end else if (ovr_at < 0) begin
         ovr_at = cyc + 1;
      end
      step(1);
   endtask

   task automatic wait_free();
      while (cyc < busy_to + 1) step(1);
   endtask

   function automatic logic [16*NCH-1:0] pack2(input int l, input int r);
      logic [16*NCH-1:0] v;
      v = '0;
      v[15:0]  = 16'(l);
      v[31:16] = 16'(r);
      return v;
   endfunction

   task automatic send(input int f, input int l, input int r);
      wait_free();
      strobe(f, pack2(l, r), 1'b1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, %0d results outstanding", sb.size());
      $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      int f;
      bus.sample_valid = 1'b0;
      bus.filter = '0;
      bus.in_data = '0;
      model_clear();
      repeat (3) @(negedge clk_144);
      chk("reset_busy", longint'(bus.busy), 0);
      chk("reset_out_valid", longint'(bus.out_valid), 0);
      chk("reset_out_data", longint'(bus.out_data), 0);
      chk("reset_overrun", longint'(bus.overrun), 0);
      reset_n = 1'b1;
      running = 1'b1;
      step(2);

      send(0, 1000, -2000);
      wait_free();
      chk("allpass_l", longint'($signed(bus.out_data[15:0])), 1000);
      chk("allpass_r", longint'($signed(bus.out_data[31:16])), -2000);

      send(1, 16384, 0);
      wait_free();
      chk("impulse_0", longint'($signed(bus.out_data[15:0])), 64);
      send(1, 0, 0);
      wait_free();
      chk("impulse_1", longint'($signed(bus.out_data[15:0])), 244);
      for (int i = 0; i < 8; i++) send(1, 0, 0);
      wait_free();
      chk("impulse_r_zero", longint'($signed(bus.out_data[31:16])), 0);

      send(2, 0, 0);
      wait_free();
      chk("filter_change_zero", longint'(bus.out_data), 0);

      for (int i = 0; i < 40; i++) send(4, 32767, $urandom_range(0, 20000));
      wait_free();
      chk("sat_pos", longint'($signed(bus.out_data[15:0])), 32767);
      for (int i = 0; i < 40; i++) send(4, -32768, -int'($urandom_range(0, 20000)));
      wait_free();
      chk("sat_neg", longint'($signed(bus.out_data[15:0])), -32768);

      // overrun: drop at +5 and in the out_valid cycle, then accept right after
      send(3, 12000, -7000);
      step(4);
      strobe(1, pack2(5, 5), 1'b0);
      while (cyc < busy_to) step(1);
      strobe(2, pack2(9, 9), 1'b0);
      strobe(3, pack2(-300, 4000), 1'b1);
      wait_free();
      chk("overrun_sticky", longint'(bus.overrun), 1);

      // reset mid-operation
      send(1, 20000, -20000);
      step(6);
      running = 1'b0;
      reset_n = 1'b0;
      sb.delete();
      model_clear();
      m_filt = 0;
      busy_from = -100;
      busy_to = -100;
      ovr_at = -1;
      last_out = '0;
      step(1);
      chk("midreset_busy", longint'(bus.busy), 0);
      chk("midreset_out_valid", longint'(bus.out_valid), 0);
      chk("midreset_out_data", longint'(bus.out_data), 0);
      chk("midreset_overrun", longint'(bus.overrun), 0);
      reset_n = 1'b1;
      step(1);
      running = 1'b1;
      step(20);
      send(0, -12345, 321);
      wait_free();
      chk("post_reset_allpass_l", longint'($signed(bus.out_data[15:0])), -12345);
      chk("post_reset_allpass_r", longint'($signed(bus.out_data[31:16])), 321);

      f = 1;
      for (int i = 0; i < 60; i++) begin
         if ($urandom_range(0, 4) == 0) f = $urandom_range(0, 7);
         if ($urandom_range(0, 5) == 0)
            send(f, ($urandom_range(0, 1) != 0) ? 32767 : -32768, int'($urandom_range(0, 65535)) - 32768);
         else
            send(f, int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 65535)) - 32768);
         if ($urandom_range(0, 3) == 0) begin
            step($urandom_range(0, 12));
            strobe($urandom_range(0, 7), (16*NCH)'($urandom), 1'b0);
         end
         step($urandom_range(0, 3));
      end
      wait_free();
      step(3);
      chk("scoreboard_drained", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
